// File: rtl/occupancy_counter_pkg.sv
// Shared definitions for the client-queue occupancy datapath.
package occ_counter_pkg;

  // Widest counter this package's helpers support.
  localparam int unsigned LIMIT_W = 32;

  // Net event decoded from the entry/exit sensors in one cycle.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } occ_event_e;

  // A runtime limit of 0 selects the full counter range (all ones at width).
  function automatic logic [LIMIT_W-1:0] eff_limit(input logic [LIMIT_W-1:0] limit,
                                                   input int unsigned        width);
    logic [LIMIT_W-1:0] ones;
    if (width >= LIMIT_W) ones = '1;
    else                  ones = (LIMIT_W'(1) << width) - LIMIT_W'(1);
    return (limit == '0) ? ones : limit;
  endfunction

  // Simultaneous entry and exit cancel out.
  function automatic occ_event_e decode_event(input logic inc, input logic dec);
    if (inc && !dec) return INC;
    if (dec && !inc) return DEC;
    return HOLD;
  endfunction

endpackage

// File: rtl/occupancy_counter_if.sv
// Control and status bundle between sensor logic, the counter and queue control.
interface occupancy_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] limit;
  logic             up;
  logic             down;
  logic             err_clr;
  logic [WIDTH-1:0] count;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             overflow_err;
  logic             underflow_err;
  logic             changed;

  modport master (
    output clear, load, load_value, limit, up, down, err_clr,
    input  count, empty, full, almost_full, overflow_err, underflow_err, changed
  );

  modport slave (
    input  clear, load, load_value, limit, up, down, err_clr,
    output count, empty, full, almost_full, overflow_err, underflow_err, changed
  );
endinterface

// File: rtl/occupancy_counter_edge_detect.sv
// 1-bit rising-edge detector with a resettable history bit.
module edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);
  logic d_q;

  // History register; reset value of 1 masks levels held through reset.
  always_ff @(posedge clk) begin
    if (!reset_n) d_q <= RESET_VAL;
    else          d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/occupancy_counter.sv
// Saturating up/down occupancy counter with runtime limit, status and sticky errors.
module occupancy_counter
  import occ_counter_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned ALMOST_MARGIN = 2,
  parameter int unsigned EDGE_MODE     = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  occupancy_counter_if.slave bus
);
  localparam int unsigned CMP_W = LIMIT_W + 1;

  logic [WIDTH-1:0] count_q, count_nxt;
  logic             ovf_q, unf_q, changed_q;
  logic             ovf_set, unf_set;
  logic             inc, dec;
  logic [WIDTH-1:0] eff;
  logic [CMP_W-1:0] eff_ext, margin_ext, thresh_ext;
  occ_event_e       ev;

  // Event qualification: raw strobes or rising edges only.
  generate
    if (EDGE_MODE == 1) begin : g_edge
      edge_detect #(.RESET_VAL(1'b1)) u_up_edge (
        .clk(clk), .reset_n(reset_n), .d(bus.up), .rise(inc)
      );
      edge_detect #(.RESET_VAL(1'b1)) u_down_edge (
        .clk(clk), .reset_n(reset_n), .d(bus.down), .rise(dec)
      );
    end else begin : g_level
      assign inc = bus.up;
      assign dec = bus.down;
    end
  endgenerate

  assign eff = WIDTH'(eff_limit(LIMIT_W'(bus.limit), WIDTH));
  assign ev  = decode_event(inc, dec);

  // Almost-full threshold, floored at zero when the margin exceeds the limit.
  assign eff_ext    = CMP_W'(eff);
  assign margin_ext = CMP_W'(ALMOST_MARGIN);
  assign thresh_ext = (eff_ext > margin_ext) ? (eff_ext - margin_ext) : '0;

  // Next count and error-set decisions; clear beats load beats events.
  always_comb begin
    count_nxt = count_q;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    if (bus.clear) begin
      count_nxt = '0;
    end else if (bus.load) begin
      if (bus.load_value <= eff) begin
        count_nxt = bus.load_value;
      end else begin
        count_nxt = eff;
        ovf_set   = 1'b1;
      end
    end else begin
      case (ev)
        INC: begin
          if (count_q < eff) count_nxt = count_q + WIDTH'(1);
          else               ovf_set   = 1'b1;
        end
        DEC: begin
          if (count_q != '0) count_nxt = count_q - WIDTH'(1);
          else               unf_set   = 1'b1;
        end
        default: count_nxt = count_q;
      endcase
    end
  end

  // State registers; a new error in the err_clr cycle keeps its flag set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      count_q   <= count_nxt;
      ovf_q     <= (ovf_q & ~bus.err_clr) | ovf_set;
      unf_q     <= (unf_q & ~bus.err_clr) | unf_set;
      changed_q <= (count_nxt != count_q);
    end
  end

  assign bus.count         = count_q;
  assign bus.empty         = (count_q == '0);
  assign bus.full          = (count_q >= eff);
  assign bus.almost_full   = (CMP_W'(count_q) >= thresh_ext);
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
  assign bus.changed       = changed_q;
endmodule

// File: tb/tb_occupancy_counter.sv
// Directed bench for occupancy_counter: strobe-mode and edge-mode instances.
module tb_occupancy_counter;
  localparam int unsigned W = 4;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  int   n_changed;

  occupancy_counter_if #(.WIDTH(W)) bus0 ();
  occupancy_counter_if #(.WIDTH(W)) bus1 ();

  occupancy_counter #(.WIDTH(W), .ALMOST_MARGIN(2), .EDGE_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  occupancy_counter #(.WIDTH(W), .ALMOST_MARGIN(2), .EDGE_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    bus0.clear = 0; bus0.load = 0; bus0.up = 0; bus0.down = 0; bus0.err_clr = 0;
  endtask

  task automatic chk_errs(input string tag, input int ovf, input int unf);
    check({tag, ".ovf"}, int'(bus0.overflow_err), ovf);
    check({tag, ".unf"}, int'(bus0.underflow_err), unf);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_changed = 0;
    reset_n = 0;
    idle0();
    bus0.load_value = '0; bus0.limit = 4'd5;
    bus1.clear = 0; bus1.load = 0; bus1.up = 0; bus1.down = 0; bus1.err_clr = 0;
    bus1.load_value = '0; bus1.limit = '0;
    #1;
    step();
    step();

    // Reset state (limit 5 -> almost threshold 3)
    check("rst.count", int'(bus0.count), 0);
    check("rst.empty", int'(bus0.empty), 1);
    check("rst.full", int'(bus0.full), 0);
    check("rst.almost", int'(bus0.almost_full), 0);
    check("rst.changed", int'(bus0.changed), 0);
    chk_errs("rst", 0, 0);
    reset_n = 1;

    // Seven up strobes against limit 5
    for (int k = 1; k <= 7; k++) begin
      bus0.up = 1;
      step();
      check($sformatf("up%0d.count", k), int'(bus0.count), (k < 5) ? k : 5);
      check($sformatf("up%0d.full", k), int'(bus0.full), (k >= 5) ? 1 : 0);
      check($sformatf("up%0d.almost", k), int'(bus0.almost_full), (k >= 3) ? 1 : 0);
      check($sformatf("up%0d.ovf", k), int'(bus0.overflow_err), (k >= 6) ? 1 : 0);
      check($sformatf("up%0d.changed", k), int'(bus0.changed), (k <= 5) ? 1 : 0);
      if (bus0.changed) n_changed++;
    end
    check("up.changed_pulses", n_changed, 5);
    idle0();
    step();
    check("hold.changed", int'(bus0.changed), 0);

    // Clear keeps the sticky error, then err_clr drops it
    bus0.clear = 1;
    step();
    check("clr.count", int'(bus0.count), 0);
    check("clr.changed", int'(bus0.changed), 1);
    check("clr.ovf", int'(bus0.overflow_err), 1);
    idle0(); bus0.err_clr = 1;
    step();
    chk_errs("eclr", 0, 0);

    // Underflow at zero
    idle0(); bus0.down = 1;
    step();
    check("unf.count", int'(bus0.count), 0);
    check("unf.changed", int'(bus0.changed), 0);
    chk_errs("unf", 0, 1);
    idle0(); bus0.err_clr = 1;
    step();
    chk_errs("unf_clr", 0, 0);

    // Load 3, then simultaneous up/down holds
    idle0(); bus0.load = 1; bus0.load_value = 4'd3;
    step();
    check("ld3.count", int'(bus0.count), 3);
    check("ld3.changed", int'(bus0.changed), 1);
    idle0(); bus0.up = 1; bus0.down = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("both%0d.count", k), int'(bus0.count), 3);
      check($sformatf("both%0d.changed", k), int'(bus0.changed), 0);
    end
    chk_errs("both", 0, 0);
    idle0(); bus0.clear = 1; bus0.up = 1;
    step();
    check("clrup.count", int'(bus0.count), 0);
    idle0(); bus0.clear = 1;
    step();
    check("clr0.changed", int'(bus0.changed), 0);

    // Clamped load, then lowered limit
    idle0(); bus0.limit = 4'd6; bus0.load = 1; bus0.load_value = 4'd9;
    step();
    check("ld9.count", int'(bus0.count), 6);
    check("ld9.full", int'(bus0.full), 1);
    chk_errs("ld9", 1, 0);
    idle0(); bus0.limit = 4'd4; bus0.err_clr = 1;
    step();
    check("lim4.count", int'(bus0.count), 6);
    check("lim4.full", int'(bus0.full), 1);
    chk_errs("lim4", 0, 0);
    idle0(); bus0.up = 1;
    step();
    check("lim4up.count", int'(bus0.count), 6);
    chk_errs("lim4up", 1, 0);
    idle0(); bus0.down = 1;
    step();
    check("lim4dn.count", int'(bus0.count), 5);
    check("lim4dn.full", int'(bus0.full), 1);
    check("lim4dn.changed", int'(bus0.changed), 1);

    // Load of an equal value is not a change
    idle0(); bus0.load = 1; bus0.load_value = 4'd5; bus0.limit = 4'd8;
    step();
    check("ldeq.count", int'(bus0.count), 5);
    check("ldeq.changed", int'(bus0.changed), 0);
    check("ldeq.full", int'(bus0.full), 0);
    check("ldeq.almost", int'(bus0.almost_full), 0);

    // Limit 0 means full range (15)
    idle0(); bus0.limit = 4'd0; bus0.load = 1; bus0.load_value = 4'd15; bus0.err_clr = 1;
    step();
    check("lim0.count", int'(bus0.count), 15);
    check("lim0.full", int'(bus0.full), 1);
    chk_errs("lim0", 0, 0);
    // err_clr with a new overflow in the same cycle: set wins
    idle0(); bus0.up = 1; bus0.err_clr = 1;
    step();
    check("lim0up.count", int'(bus0.count), 15);
    chk_errs("setwins", 1, 0);

    // Mid-count reset overrides everything
    idle0(); bus0.down = 1;
    step();
    check("pre_rst.count", int'(bus0.count), 14);
    reset_n = 0; bus0.up = 1; bus0.down = 0; bus0.load = 1; bus0.load_value = 4'd7;
    step();
    check("midrst.count", int'(bus0.count), 0);
    check("midrst.changed", int'(bus0.changed), 0);
    chk_errs("midrst", 0, 0);
    idle0();

    // Edge mode: level held through reset release is not counted
    bus1.up = 1;
    step();
    reset_n = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("edge_hold%0d.count", k), int'(bus1.count), 0);
    end
    bus1.up = 0;
    step();
    check("edge_low.count", int'(bus1.count), 0);
    bus1.up = 1;
    step();
    check("edge_rise.count", int'(bus1.count), 1);
    check("edge_rise.changed", int'(bus1.changed), 1);
    step();
    step();
    check("edge_level.count", int'(bus1.count), 1);
    check("edge_level.changed", int'(bus1.changed), 0);
    check("edge.ovf", int'(bus1.overflow_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/occupancy_counter.md
# occupancy_counter

Parametrised saturating up/down occupancy counter for the client-queue datapath. It tracks how many clients are in the queue and supports:
- a width and capacity limit that can change at run time;
- synchronous clear and load;
- optional rising-edge qualification of the sensor strobes;
- full, empty and almost-full status flags;
- sticky overflow and underflow error flags.

It sits between the entry/exit sensor logic and the display/queue-control logic.

## Interface
- WIDTH, 4, counter width in bits.
- ALMOST_MARGIN, 2, almost_full asserts when count >= eff_limit − ALMOST_MARGIN. The subtraction floors at 0.
- EDGE_MODE, 0, selects how up/down are interpreted:
  - 0: up/down are per-cycle strobes.
  - 1: only a rising edge of up/down is an event.

- clk  in  1  clock, rising edge.
- reset_n  in  1  reset; synchronous, active-low.
- clear  in  1  synchronous clear of the count to 0.
- load  in  1  loads load_value into the count.
- load_value  in  WIDTH  value for load.
- limit  in  WIDTH  runtime capacity. 0 means eff_limit = 2^WIDTH−1.
- up  in  1  client-entered event.
- down  in  1  client-left event.
- err_clr  in  1  clears both sticky error flags.
- count  out  WIDTH  current occupancy, registered.
- empty  out  1  count == 0.
- full  out  1  count >= eff_limit.
- almost_full  out  1  see ALMOST_MARGIN.
- overflow_err  out  1  sticky; set by a rejected increment or a clamped load.
- underflow_err  out  1  sticky; set by a rejected decrement.
- changed  out  1  one-cycle pulse, registered; high in the cycle after count changes value.

## Operation
- **Reset** (reset_n = 0 at a clk edge):
  - count = 0, overflow_err = 0, underflow_err = 0, changed = 0.
  - Edge-detect history registers are set to 1, so inputs held high through reset are not counted.
  - After reset: empty = 1, full = 0, almost_full = 1 only if eff_limit <= ALMOST_MARGIN.
- **Priority per cycle:** reset_n > clear > load > up/down events.
- **clear:** count ← 0. Pending events in that cycle are discarded. Error flags are untouched.
- **load:**
  - load_value <= eff_limit: count ← load_value.
  - Otherwise: count ← eff_limit and overflow_err set.
  - up/down in that cycle are ignored.
- **Event evaluation** (inc = up event, dec = down event):
  - inc & dec: count holds; no error (one in, one out).
  - inc only, count < eff_limit: count + 1.
  - inc only, count >= eff_limit: count holds; overflow_err set.
  - dec only, count > 0: count − 1.
  - dec only, count == 0: count holds; underflow_err set.
- **Wrap-around:** never. Arithmetic is WIDTH bits and saturating.
- **Limit lowered below count:** count is not modified. full asserts, increments are rejected (with error), decrements proceed normally.
- **err_clr:** clears both sticky flags. If a new error occurs in the same cycle, set wins.
- **Flags:** empty, full and almost_full are combinational from the count register and the current limit. No pipeline stage.
- **EDGE_MODE = 1:** event = input & ~input_q, where input_q is a 1-cycle history register. The history updates every cycle, including during clear and load.

## Timing
- Event at the edge N input → count updated after edge N. Latency is one clock in both modes; the edge detect adds no cycle.
- Flags track count in the same cycle the count is visible.
- changed is high for exactly the cycle after the count update. It stays low on a hold, on a clear from 0, and on a load of an equal value.
- Errors are visible the cycle after the offending event.
- EDGE_MODE = 1: a level held high counts once. Re-triggering needs at least one low cycle.
- reset_n asserted mid-operation takes effect at the next edge, regardless of other inputs.

## Structure
- Package occ_counter_pkg holds:
  - function eff_limit(limit, WIDTH), which maps 0 to all-ones;
  - the shared event-decode encoding (INC, DEC, HOLD), used by queue-control logic as well.
- One sub-module, edge_detect: 1-bit rising-edge detector.
  - Parameter RESET_VAL; synchronous active-low reset.
  - Instantiated twice under a generate when EDGE_MODE = 1. Otherwise it is bypassed.

## Test plan
- WIDTH = 4, limit = 5, 7 up strobes:
  - count goes 1..5, then holds at 5.
  - full rises at 5; almost_full rises at 3.
  - overflow_err set after the 6th strobe; changed pulses 5 times.
- count = 0, down strobe → count stays 0, underflow_err = 1, changed = 0. Then err_clr alone → underflow_err = 0.
- count = 3, up & down together for 4 cycles → count stays 3, no errors. Then clear + up in the same cycle → count = 0.
- limit = 6, load_value = 9 → count = 6, overflow_err = 1. Then limit changed to 4 → full = 1; up rejected; down → 5.
- EDGE_MODE = 1:
  - up held high through reset release and for 5 cycles → count stays 0.
  - up low 1 cycle, then high 3 cycles → count = 1.
- Mid-count reset_n low for 1 cycle → next cycle count = 0, all error flags 0, changed = 0.
